display_reader: RTL and testbench
=================================

DISPLAY_READER -- requirements
Module: display_reader

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed display digits observed.
REQ-002 Parameter STABLE, default 3: consecutive identical samples required before a digit is captured; legal range 2..15.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 segmentos  input  7 ([0:6])  observed segment pattern, active-high, segmentos[0]=a ... segmentos[6]=g.
REQ-006 digito_sel  input  DIGITS  one-hot digit strobe; bit i high = segmentos currently belongs to digit i.
REQ-007 pronto  input  1  consumer ready.
REQ-008 valor  output  4*DIGITS  recovered hex frame; digit i at valor[4i+3:4i].
REQ-009 erro  output  DIGITS  per-digit flag: captured pattern was not a legal hex glyph.
REQ-010 valido  output  1  valor/erro hold a frame not yet accepted.

Function
REQ-011 Encoding SHALL be the exact inverse of the team hex-to-segment glyph table (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-012 Any other 7-bit pattern SHALL be invalid: nibble 0, erro bit set for that digit.
REQ-013 On every rising edge the block SHALL register (digito_sel, segmentos) and compare against the previous registered pair.
REQ-014 Stability counter: identical pair -> increment, saturating at STABLE; different pair -> load 1.
REQ-015 digito_sel zero or not one-hot -> counter loads 0, no capture, previous pair still updated.
REQ-016 Capture SHALL occur exactly on the edge where the counter reaches STABLE: encoded nibble and error bit written to the slot of the selected digit, slot marked captured; no further capture until the run breaks.
REQ-017 A re-capture of an already captured slot before frame transfer SHALL overwrite it (newest wins).
REQ-018 Output FSM states: VAZIO (valido=0) and CHEIO (valido=1).
REQ-019 Frame complete = all DIGITS slots captured; transfer SHALL occur on the edge after completion when in VAZIO, or on the edge where valido=1 and pronto=1.
REQ-020 Transfer: valor/erro loaded from slots, all captured marks cleared, state CHEIO; a capture on the same edge SHALL land in the cleared slot set.
REQ-021 In CHEIO with pronto=0, valor, erro, valido SHALL hold stable; slot captures continue.
REQ-022 In CHEIO with pronto=1 and no complete frame: next state VAZIO, valido=0, valor/erro retain last values.
REQ-023 In CHEIO with pronto=1 and a complete frame: transfer same edge, valido stays 1 (back-to-back, no bubble).
REQ-024 Latency: last digit's STABLE-th identical sample at edge t -> valido=1 after edge t+1 when output free.

Reset
REQ-025 reset_n=0 at a rising edge SHALL set valor=0, erro=0, valido=0, state VAZIO, all captured marks 0, counter 0, previous pair 0; reset overrides all simultaneous events.
REQ-026 Partial frames SHALL be discarded by reset; a full new frame is required afterwards.

Verification (DIGITS=4, STABLE=3)
REQ-027 Digits 0..3 driven 3 cycles each with 1111110, 0110000, 1101101, 1111001, pronto=1 -> valido pulses 1 cycle, one edge after last capture, valor=16'h3210, erro=4'b0000.
REQ-028 digit 2 shows 1111111 for only 2 cycles then changes -> no capture for digit 2, valido stays 0.
REQ-029 digit 1 shows 0000001 for 3 cycles, others legal (0,_,2,3) -> valor=16'h3200, erro=4'b0010.
REQ-030 pronto=0 holding frame 16'h3210, second frame 16'hFEDC completes -> valor stays 16'h3210; pronto=1 -> next edge valor=16'hFEDC, valido remains 1.
REQ-031 reset_n=0 one cycle after 2 digits captured -> all outputs 0 next edge; driving only digits 2,3 afterwards yields no valido.
REQ-032 digito_sel=4'b0011 with 1111110 for 5 cycles -> no capture, counter 0, valido 0.

Source files
------------

// File: rtl/display_reader_if.sv
// ---------------------------------------------------------------------------
// display_reader_if
// Purpose : groups the observed display bus and the recovered-frame handshake
//           used by display_reader.
// Signals : segmentos  [0:6]         observed segments, [0]=a ... [6]=g
//           digito_sel [DIGITS-1:0]  one-hot digit strobe
//           pronto                   consumer ready
//           valor      [4*DIGITS-1:0] recovered hex frame, digit i at [4i+3:4i]
//           erro       [DIGITS-1:0]  per-digit illegal-glyph flag
//           valido                   valor/erro hold a frame not yet accepted
// Modports: master drives the display bus and pronto, slave is the reader.
// ---------------------------------------------------------------------------
interface display_reader_if #(
  parameter int DIGITS = 4
);
  logic [0:6]          segmentos;
  logic [DIGITS-1:0]   digito_sel;
  logic                pronto;
  logic [4*DIGITS-1:0] valor;
  logic [DIGITS-1:0]   erro;
  logic                valido;

  modport master (
    output segmentos,
    output digito_sel,
    output pronto,
    input  valor,
    input  erro,
    input  valido
  );

  modport slave (
    input  segmentos,
    input  digito_sel,
    input  pronto,
    output valor,
    output erro,
    output valido
  );
endinterface

// File: rtl/display_reader.sv
// ---------------------------------------------------------------------------
// display_reader
// Purpose : watches a multiplexed 7-segment display, debounces each digit
//           (a digit is captured after STABLE identical samples), decodes the
//           glyph back to a hex nibble and hands out complete frames through
//           a valid/ready style handshake.
// Ports   : clock    rising-edge clock for all state
//           reset_n  synchronous active-low reset
//           bus      display_reader_if.slave (segmentos, digito_sel, pronto in;
//                    valor, erro, valido out)
// ---------------------------------------------------------------------------
module display_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  display_reader_if.slave    bus
);

  localparam logic [3:0] STABLE_L = 4'(STABLE);

  typedef enum logic {
    VAZIO,
    CHEIO
  } outState_e;

  // Inverse of the hex-to-segment glyph table. Returns {error, nibble};
  // anything that is not one of the sixteen glyphs decodes to error + 0.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b1_0000;
    case (seg)
      7'b1111110: res = 5'h00;
      7'b0110000: res = 5'h01;
      7'b1101101: res = 5'h02;
      7'b1111001: res = 5'h03;
      7'b0110011: res = 5'h04;
      7'b1011011: res = 5'h05;
      7'b1011111: res = 5'h06;
      7'b1110000: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1111011: res = 5'h09;
      7'b1110111: res = 5'h0A;
      7'b0011111: res = 5'h0B;
      7'b1001110: res = 5'h0C;
      7'b0111101: res = 5'h0D;
      7'b1001111: res = 5'h0E;
      7'b1000111: res = 5'h0F;
      default:    res = 5'b1_0000;
    endcase
    return res;
  endfunction

  logic [DIGITS-1:0]   r_prevSel;
  logic [6:0]          r_prevSeg;
  logic [3:0]          r_count;
  logic [4*DIGITS-1:0] r_slotVal;
  logic [DIGITS-1:0]   r_slotErr;
  logic [DIGITS-1:0]   r_captured;
  logic [4*DIGITS-1:0] r_valor;
  logic [DIGITS-1:0]   r_erro;
  outState_e           r_state;

  logic [6:0]          w_seg;
  logic                w_oneHot;
  logic                w_samePair;
  logic [3:0]          w_countNext;
  logic                w_capture;
  logic [4:0]          w_decoded;
  logic                w_frameDone;
  logic                w_transfer;
  outState_e           w_stateNext;
  logic [DIGITS-1:0]   w_capturedNext;

  // segmentos is declared [0:6], so a copy into [6:0] puts segment a in the
  // MSB, matching the way the glyph table is written.
  assign w_seg      = bus.segmentos;
  assign w_oneHot   = $onehot(bus.digito_sel);
  assign w_samePair = (bus.digito_sel == r_prevSel) && (w_seg == r_prevSeg);
  assign w_decoded  = decodeGlyph(w_seg);

  // Stability counter. Capture fires only on the step from STABLE-1 to
  // STABLE; once saturated the run must break before another capture.
  always_comb begin
    w_countNext = r_count;
    if (!w_oneHot) begin
      w_countNext = 4'd0;
    end else if (w_samePair) begin
      if (r_count < STABLE_L) begin
        w_countNext = r_count + 4'd1;
      end
    end else begin
      w_countNext = 4'd1;
    end
  end

  assign w_capture = w_oneHot && w_samePair && (r_count == STABLE_L - 4'd1);

  // Output FSM next state and frame transfer decision. The captured marks
  // are cleared on transfer first so a capture on the same edge starts the
  // next frame instead of being lost.
  always_comb begin
    w_frameDone    = &r_captured;
    w_transfer     = w_frameDone && ((r_state == VAZIO) || bus.pronto);
    w_stateNext    = r_state;
    w_capturedNext = w_transfer ? '0 : r_captured;
    if (w_capture) begin
      w_capturedNext = w_capturedNext | bus.digito_sel;
    end
    if (w_transfer) begin
      w_stateNext = CHEIO;
    end else if ((r_state == CHEIO) && bus.pronto) begin
      w_stateNext = VAZIO;
    end
  end

  // Sample pipeline, counter, slot storage and captured marks.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_prevSel  <= '0;
      r_prevSeg  <= '0;
      r_count    <= 4'd0;
      r_slotVal  <= '0;
      r_slotErr  <= '0;
      r_captured <= '0;
    end else begin
      r_prevSel  <= bus.digito_sel;
      r_prevSeg  <= w_seg;
      r_count    <= w_countNext;
      r_captured <= w_capturedNext;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_capture && bus.digito_sel[i]) begin
          r_slotVal[4*i +: 4] <= w_decoded[3:0];
          r_slotErr[i]        <= w_decoded[4];
        end
      end
    end
  end

  // State register and the frame held on the outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= VAZIO;
      r_valor <= '0;
      r_erro  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_transfer) begin
        r_valor <= r_slotVal;
        r_erro  <= r_slotErr;
      end
    end
  end

  assign bus.valor  = r_valor;
  assign bus.erro   = r_erro;
  assign bus.valido = (r_state == CHEIO);

endmodule

// File: tb/tb_display_reader.sv
// ---------------------------------------------------------------------------
// tb_display_reader
// Purpose : directed self-checking bench for display_reader (DIGITS=4,
//           STABLE=3). Inputs change and outputs are checked on the falling
//           edge, half a cycle away from the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_display_reader;

  logic clock;
  logic reset_n;
  int   testsRun;
  int   failCount;

  display_reader_if #(.DIGITS(4)) busIf ();

  display_reader #(
    .DIGITS(4),
    .STABLE(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (busIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one digit/segment pair and let it sit for the given number of
  // rising edges; returns on the falling edge after the last one.
  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg,
                               input int cycles);
    busIf.digito_sel = sel;
    busIf.segmentos  = seg;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    applyStimulus(4'b0000, 7'b0000000, cycles);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun   = 0;
    failCount  = 0;
    reset_n    = 1'b0;
    busIf.pronto     = 1'b1;
    busIf.digito_sel = 4'b0000;
    busIf.segmentos  = 7'b0000000;
    repeat (2) @(negedge clock);
    checkOutput("reset_valido", 32'(busIf.valido), 32'h0);
    checkOutput("reset_valor",  32'(busIf.valor),  32'h0);
    checkOutput("reset_erro",   32'(busIf.erro),   32'h0);
    checkOutput("reset_count",  32'(dut.r_count),  32'h0);
    reset_n = 1'b1;

    // Basic frame 3210 with consumer ready: one-cycle valid pulse.
    applyStimulus(4'b0001, 7'b1111110, 3);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b1101101, 3);
    applyStimulus(4'b1000, 7'b1111001, 3);
    checkOutput("basic_valido_latency", 32'(busIf.valido), 32'h0);
    idle(1);
    checkOutput("basic_valido", 32'(busIf.valido), 32'h1);
    checkOutput("basic_valor",  32'(busIf.valor),  32'h3210);
    checkOutput("basic_erro",   32'(busIf.erro),   32'h0);
    idle(1);
    checkOutput("basic_pulse_end", 32'(busIf.valido), 32'h0);
    checkOutput("basic_valor_hold", 32'(busIf.valor), 32'h3210);

    // Digit 2 unstable for only two samples: frame must not complete.
    applyStimulus(4'b0001, 7'b1111110, 3);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b1111111, 2);
    applyStimulus(4'b1000, 7'b1111001, 3);
    idle(2);
    checkOutput("short_run_no_valido", 32'(busIf.valido), 32'h0);
    applyStimulus(4'b0100, 7'b1111111, 3);
    idle(1);
    checkOutput("short_run_fill_valido", 32'(busIf.valido), 32'h1);
    checkOutput("short_run_fill_valor",  32'(busIf.valor),  32'h3810);
    idle(1);

    // Illegal glyph on digit 1.
    applyStimulus(4'b0001, 7'b1111110, 3);
    applyStimulus(4'b0010, 7'b0000001, 3);
    applyStimulus(4'b0100, 7'b1101101, 3);
    applyStimulus(4'b1000, 7'b1111001, 3);
    idle(1);
    checkOutput("bad_glyph_valido", 32'(busIf.valido), 32'h1);
    checkOutput("bad_glyph_valor",  32'(busIf.valor),  32'h3200);
    checkOutput("bad_glyph_erro",   32'(busIf.erro),   32'h2);
    idle(1);

    // Re-capture of digit 0 before transfer: newest value wins.
    applyStimulus(4'b0001, 7'b0110000, 3);
    applyStimulus(4'b0001, 7'b1011011, 3);
    applyStimulus(4'b0010, 7'b1110000, 3);
    applyStimulus(4'b0100, 7'b0110011, 3);
    applyStimulus(4'b1000, 7'b1011111, 3);
    idle(1);
    checkOutput("recapture_valor", 32'(busIf.valor), 32'h6475);
    checkOutput("recapture_erro",  32'(busIf.erro),  32'h0);
    idle(1);
    checkOutput("recapture_pulse_end", 32'(busIf.valido), 32'h0);

    // Backpressure: frame 3210 held while FEDC completes, then handed over
    // back to back when the consumer becomes ready.
    busIf.pronto = 1'b0;
    applyStimulus(4'b0001, 7'b1111110, 3);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b1101101, 3);
    applyStimulus(4'b1000, 7'b1111001, 3);
    idle(1);
    checkOutput("stall_first_valido", 32'(busIf.valido), 32'h1);
    checkOutput("stall_first_valor",  32'(busIf.valor),  32'h3210);
    applyStimulus(4'b0001, 7'b1001110, 3);
    applyStimulus(4'b0010, 7'b0111101, 3);
    applyStimulus(4'b0100, 7'b1001111, 3);
    applyStimulus(4'b1000, 7'b1000111, 3);
    idle(2);
    checkOutput("stall_hold_valido", 32'(busIf.valido), 32'h1);
    checkOutput("stall_hold_valor",  32'(busIf.valor),  32'h3210);
    busIf.pronto = 1'b1;
    idle(1);
    checkOutput("b2b_valido", 32'(busIf.valido), 32'h1);
    checkOutput("b2b_valor",  32'(busIf.valor),  32'hFEDC);
    checkOutput("b2b_erro",   32'(busIf.erro),   32'h0);
    idle(1);
    checkOutput("b2b_drain_valido", 32'(busIf.valido), 32'h0);
    checkOutput("b2b_drain_valor",  32'(busIf.valor),  32'hFEDC);

    // Reset with a partial frame: outputs clear and the partial is lost.
    applyStimulus(4'b0001, 7'b1111110, 3);
    applyStimulus(4'b0010, 7'b0110000, 3);
    idle(1);
    reset_n = 1'b0;
    idle(1);
    checkOutput("midreset_valor",  32'(busIf.valor),  32'h0);
    checkOutput("midreset_erro",   32'(busIf.erro),   32'h0);
    checkOutput("midreset_valido", 32'(busIf.valido), 32'h0);
    reset_n = 1'b1;
    applyStimulus(4'b0100, 7'b1110111, 3);
    applyStimulus(4'b1000, 7'b0011111, 3);
    idle(2);
    checkOutput("partial_discarded", 32'(busIf.valido), 32'h0);

    // Two strobes at once never count as stable and never capture.
    applyStimulus(4'b0011, 7'b1111110, 5);
    checkOutput("multi_sel_count",  32'(dut.r_count),  32'h0);
    checkOutput("multi_sel_valido", 32'(busIf.valido), 32'h0);
    applyStimulus(4'b0010, 7'b1111011, 3);
    idle(2);
    checkOutput("multi_sel_no_capture", 32'(busIf.valido), 32'h0);
    applyStimulus(4'b0001, 7'b1011111, 3);
    idle(1);
    checkOutput("after_reset_valido", 32'(busIf.valido), 32'h1);
    checkOutput("after_reset_valor",  32'(busIf.valor),  32'hBA96);
    checkOutput("after_reset_erro",   32'(busIf.erro),   32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
